sandbox_frame_bridge: RTL

- Host-side framing engine between the byte-level UART (rx/tx byte interfaces) and a sandbox process.
- RX path: assembles 5-byte host frames (control + 32-bit data) and presents them with a dataReceived/clearDR handshake.
- TX path: on a transmit request from the process, serializes status + 32-bit outputData into 5 UART bytes.
- RX and TX paths are independent state machines and may run concurrently.

---
 rtl/sandbox_frame_pkg.sv | 44 ++++
 rtl/sandbox_frame_tx.sv | 85 ++++++++
 rtl/sandbox_frame_bridge.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/sandbox_frame_pkg.sv
// Shared constants, state encodings and checksum helper for the sandbox frame bridge.
// SANDBOX_FRAME_CHECKSUM_EN adds a trailing XOR byte to frames in both directions.
package sandbox_frame_pkg;

   localparam int FRAME_BYTES = 5;
`ifdef SANDBOX_FRAME_CHECKSUM_EN
   localparam int CSUM_BYTES = 1;
`else
   localparam int CSUM_BYTES = 0;
`endif
   localparam int WIRE_BYTES = FRAME_BYTES + CSUM_BYTES;
   localparam logic [2:0] LAST_IDX = 3'(WIRE_BYTES - 1);

   localparam logic [1:0] RS_IDLE    = 2'd0;
   localparam logic [1:0] RS_COLLECT = 2'd1;
   localparam logic [1:0] RS_PRESENT = 2'd2;
   localparam logic [1:0] RS_WAITREL = 2'd3;

   localparam logic [2:0] TS_IDLE = 3'd0;
   localparam logic [2:0] TS_LOAD = 3'd1;
   localparam logic [2:0] TS_SEND = 3'd2;
   localparam logic [2:0] TS_GAP  = 3'd3;
   localparam logic [2:0] TS_WAIT = 3'd4;

   typedef enum logic [1:0] {
      R_IDLE    = RS_IDLE,
      R_COLLECT = RS_COLLECT,
      R_PRESENT = RS_PRESENT,
      R_WAITREL = RS_WAITREL
   } rx_state_e;

   typedef enum logic [2:0] {
      T_IDLE = TS_IDLE,
      T_LOAD = TS_LOAD,
      T_SEND = TS_SEND,
      T_GAP  = TS_GAP,
      T_WAIT = TS_WAIT
   } tx_state_e;

   function automatic logic [7:0] frame_xor(input logic [39:0] f);
      return f[39:32] ^ f[31:24] ^ f[23:16] ^ f[15:8] ^ f[7:0];
   endfunction

endpackage

// File: rtl/sandbox_frame_tx.sv
// TX framing: edge-detects transmitData, snapshots status/outputData, serializes to UART.
// SANDBOX_FRAME_CHECKSUM_EN appends the XOR of the five payload bytes.
module sandbox_frame_tx
   import sandbox_frame_pkg::*;
(
   input  logic        masterClock,
   input  logic        reset,
   input  logic        transmitData,
   input  logic [7:0]  status,
   input  logic [31:0] outputData,
   input  logic        txBusy,
   output logic [7:0]  txByte,
   output logic        txStart
);

   localparam int TX_W = 8 * WIRE_BYTES;

   tx_state_e   ts_q, ts_d;
   logic [TX_W-1:0] sh_q, sh_d;
   logic [2:0]  n_q, n_d;
   logic [7:0]  byte_q, byte_d;
   logic        start_q, start_d;
   logic        td_q;
   logic        rise;
   logic [TX_W-1:0] snap;

`ifdef SANDBOX_FRAME_CHECKSUM_EN
   assign snap = {status, outputData, frame_xor({status, outputData})};
`else
   assign snap = {status, outputData};
`endif

   assign rise = transmitData & ~td_q;

   always_comb begin
      ts_d    = ts_q;
      sh_d    = sh_q;
      n_d     = n_q;
      byte_d  = byte_q;
      start_d = 1'b0;
      unique case (ts_q)
         T_IDLE: if (rise) begin
            sh_d = snap;
            n_d  = 3'd0;
            ts_d = T_LOAD;
         end
         T_LOAD: ts_d = T_SEND;
         T_SEND: if (!txBusy) begin
            byte_d  = sh_q[TX_W-1 -: 8];
            start_d = 1'b1;
            ts_d    = T_GAP;
         end
         // transmitter only raises busy after it has seen txStart
         T_GAP: ts_d = T_WAIT;
         T_WAIT: if (!txBusy) begin
            sh_d = {sh_q[TX_W-9:0], 8'h00};
            n_d  = n_q + 3'd1;
            ts_d = (n_q == LAST_IDX) ? T_IDLE : T_SEND;
         end
         default: ts_d = T_IDLE;
      endcase
   end

   always_ff @(posedge masterClock) begin
      if (!reset) begin
         ts_q    <= T_IDLE;
         sh_q    <= '0;
         n_q     <= '0;
         byte_q  <= '0;
         start_q <= 1'b0;
         td_q    <= 1'b0;
      end else begin
         ts_q    <= ts_d;
         sh_q    <= sh_d;
         n_q     <= n_d;
         byte_q  <= byte_d;
         start_q <= start_d;
         td_q    <= transmitData;
      end
   end

   assign txByte  = byte_q;
   assign txStart = start_q;

endmodule

// File: rtl/sandbox_frame_bridge.sv
// Host framing bridge: RX frame assembly with clearDR handshake, TX via sandbox_frame_tx.
// SANDBOX_FRAME_CHECKSUM_EN adds the XOR byte and the csumErr pulse output.
module sandbox_frame_bridge
   import sandbox_frame_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int TO_WIDTH       = 20
) (
   input  logic        masterClock,
   input  logic        reset,
   input  logic [7:0]  rxByte,
   input  logic        rxValid,
   output logic [7:0]  txByte,
   output logic        txStart,
   input  logic        txBusy,
   output logic        dataReceived,
   output logic [7:0]  control,
   output logic [31:0] inputData,
   input  logic        clearDR,
   input  logic        transmitData,
   input  logic [7:0]  status,
   input  logic [31:0] outputData,
   output logic        overrun,
   output logic        timeoutErr
`ifdef SANDBOX_FRAME_CHECKSUM_EN
   ,output logic       csumErr
`endif
);

   localparam int SH_W = 24 + 8 * CSUM_BYTES;

   rx_state_e rs_q, rs_d;
   logic [2:0]          idx_q, idx_d;
   logic [SH_W-1:0]     sh_q, sh_d;
   logic [7:0]          ctl_q, ctl_d;
   logic [31:0]         dat_q, dat_d;
   logic                dr_q, dr_d;
   logic                ovr_q, ovr_d;
   logic                to_q, to_d;
   logic [TO_WIDTH-1:0] cnt_q, cnt_d;
`ifdef SANDBOX_FRAME_CHECKSUM_EN
   logic [7:0]          cs_q, cs_d;
   logic                ce_q, ce_d;
`endif

   always_comb begin
      rs_d  = rs_q;
      idx_d = idx_q;
      sh_d  = sh_q;
      ctl_d = ctl_q;
      dat_d = dat_q;
      dr_d  = dr_q;
      ovr_d = ovr_q;
      to_d  = 1'b0;
      cnt_d = cnt_q;
`ifdef SANDBOX_FRAME_CHECKSUM_EN
      cs_d  = cs_q;
      ce_d  = 1'b0;
`endif
      unique case (rs_q)
         R_IDLE: if (rxValid) begin
            ctl_d = rxByte;
            idx_d = 3'd1;
            sh_d  = '0;
            cnt_d = '0;
`ifdef SANDBOX_FRAME_CHECKSUM_EN
            cs_d  = rxByte;
`endif
            rs_d  = R_COLLECT;
         end
         R_COLLECT: if (rxValid) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
            sh_d  = {sh_q[SH_W-9:0], rxByte};
`ifdef SANDBOX_FRAME_CHECKSUM_EN
            cs_d  = cs_q ^ rxByte;
`endif
            if (idx_q == LAST_IDX) begin
`ifdef SANDBOX_FRAME_CHECKSUM_EN
               if (rxByte == cs_q) begin
                  dat_d = sh_q;
                  dr_d  = 1'b1;
                  rs_d  = R_PRESENT;
               end else begin
                  ce_d = 1'b1;
                  rs_d = R_IDLE;
               end
`else
               dat_d = {sh_q, rxByte};
               dr_d  = 1'b1;
               rs_d  = R_PRESENT;
`endif
            end
         end else if (cnt_q == TO_WIDTH'(TIMEOUT_CYCLES - 1)) begin
            to_d  = 1'b1;
            cnt_d = '0;
            rs_d  = R_IDLE;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
         R_PRESENT: begin
            if (rxValid) ovr_d = 1'b1;
            if (clearDR) begin
               dr_d = 1'b0;
               rs_d = R_WAITREL;
            end
         end
         // hold off a new frame until the process drops its acknowledge
         R_WAITREL: begin
            if (rxValid) ovr_d = 1'b1;
            if (!clearDR) rs_d = R_IDLE;
         end
         default: rs_d = R_IDLE;
      endcase
   end

   always_ff @(posedge masterClock) begin
      if (!reset) begin
         rs_q  <= R_IDLE;
         idx_q <= '0;
         sh_q  <= '0;
         ctl_q <= '0;
         dat_q <= '0;
         dr_q  <= 1'b0;
         ovr_q <= 1'b0;
         to_q  <= 1'b0;
         cnt_q <= '0;
`ifdef SANDBOX_FRAME_CHECKSUM_EN
         cs_q  <= '0;
         ce_q  <= 1'b0;
`endif
      end else begin
         rs_q  <= rs_d;
         idx_q <= idx_d;
         sh_q  <= sh_d;
         ctl_q <= ctl_d;
         dat_q <= dat_d;
         dr_q  <= dr_d;
         ovr_q <= ovr_d;
         to_q  <= to_d;
         cnt_q <= cnt_d;
`ifdef SANDBOX_FRAME_CHECKSUM_EN
         cs_q  <= cs_d;
         ce_q  <= ce_d;
`endif
      end
   end

   assign dataReceived = dr_q;
   assign control      = ctl_q;
   assign inputData    = dat_q;
   assign overrun      = ovr_q;
   assign timeoutErr   = to_q;
`ifdef SANDBOX_FRAME_CHECKSUM_EN
   assign csumErr      = ce_q;
`endif

   sandbox_frame_tx u_tx (
      .masterClock  (masterClock),
      .reset        (reset),
      .transmitData (transmitData),
      .status       (status),
      .outputData   (outputData),
      .txBusy       (txBusy),
      .txByte       (txByte),
      .txStart      (txStart)
   );

endmodule
